pipe_stage_latch: RTL and testbench
===================================

PIPE_STAGE_LATCH -- requirements
Module: pipe_stage_latch

Interface
REQ-001 SHALL take parameter PC_W, default 32, program-count field width.
REQ-002 SHALL take parameter IR_W, default 32, instruction field width.
REQ-003 SHALL take parameter NOP_IR, default 0, instruction value presented when no valid entry is held.
REQ-004 SHALL take parameter CNT_W, default 16, stall-counter width.
REQ-005 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-007 SHALL have port in_valid  in  1  upstream entry present.
REQ-008 SHALL have port in_ready  out  1  stage accepts an entry this cycle.
REQ-009 SHALL have port in_pc  in  PC_W  upstream program count.
REQ-010 SHALL have port in_ir  in  IR_W  upstream instruction.
REQ-011 SHALL have port flush  in  1  discard all held entries and the current input.
REQ-012 SHALL have port out_valid  out  1  downstream entry present.
REQ-013 SHALL have port out_ready  in  1  downstream accepts an entry.
REQ-014 SHALL have port out_pc  out  PC_W  program count of the head entry.
REQ-015 SHALL have port out_ir  out  IR_W  instruction of the head entry.
REQ-016 SHALL have port stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 SHALL hold up to two entries: a main register (head) and a skid register.
REQ-018 SHALL implement states EMPTY, FULL (main only) and SKID (main and skid).
REQ-019 SHALL define an input transfer as in_valid & in_ready, and an output transfer as out_valid & out_ready.
REQ-020 SHALL drive in_ready directly from state: 1 in EMPTY and FULL, 0 in SKID, with no combinational path from out_ready.
REQ-021 SHALL drive out_valid = 1 in FULL and SKID, and 0 in EMPTY.
REQ-022 SHALL, when out_valid=0, drive out_ir=NOP_IR and out_pc=0; otherwise drive the main register contents.
REQ-023 SHALL transition from EMPTY on in_valid to FULL, loading main; latency input-to-output is 1 cycle.
REQ-024 SHALL handle FULL as follows:
- in_valid & out_ready: stay in FULL and load main from input, giving 1 entry/cycle throughput.
- out_ready only: go to EMPTY.
- in_valid only: go to SKID and load skid from input.
- neither: hold.
REQ-025 SHALL, in SKID with out_ready=1, move skid into main and go to FULL; with out_ready=0 it SHALL hold both entries.
REQ-026 SHALL give flush priority over every other event: the next state is EMPTY, both registers are loaded with pc=0 and ir=NOP_IR, and any simultaneous input transfer is dropped.
REQ-027 SHALL never lose, duplicate or reorder an entry absent flush; entries leave in acceptance order.
REQ-028 SHALL increment stall_cnt each cycle out_valid=1 and out_ready=0, saturate at all-ones, and leave it unaffected by flush.

Reset
REQ-029 SHALL, while reset=0, asynchronously force state EMPTY, main and skid to pc=0 / ir=NOP_IR, and stall_cnt=0.
REQ-030 SHALL, during and immediately after reset, present in_ready=1, out_valid=0, out_pc=0, out_ir=NOP_IR and stall_cnt=0.
REQ-031 SHALL, if reset is asserted mid-operation, discard held entries with no partial transfer.

Structure
REQ-032 SHALL take the state encoding (EMPTY, FULL, SKID) and the default NOP_IR constant from the shared cpu package.
REQ-033 SHALL instantiate the existing 32-bit write-enable register sub-module (reg32bit) for the main and skid fields when PC_W=IR_W=32; otherwise it SHALL use generic registers.

Verification
REQ-034 SHALL cover: reset released, in_valid=1 with pc=0x4 and ir=0x2000_0001 -> next cycle out_valid=1, out_pc=0x4, out_ir=0x2000_0001.
REQ-035 SHALL cover: streaming pc=0x0,0x4,0x8 with out_ready=1 -> output sequence identical, one per cycle, in_ready held at 1.
REQ-036 SHALL cover: FULL with out_ready=0 and a new entry pc=0x8 -> SKID, in_ready=0; then out_ready=1 -> outputs pc=0x4 then pc=0x8.
REQ-037 SHALL cover: SKID with flush=1 and in_valid=1 -> next cycle out_valid=0, out_ir=NOP_IR, in_ready=1, and the input entry is never output.
REQ-038 SHALL cover: out_ready held 0 for 2^CNT_W+5 cycles with out_valid=1 -> stall_cnt saturates at all-ones.
REQ-039 SHALL cover: reset pulled low mid-stream in SKID -> immediately out_valid=0, stall_cnt=0, in_ready=1.

Source files
------------

// File: rtl/pipe_stage_latch_pkg.sv
// Shared cpu package for the pipeline stage latch.
// Holds the occupancy-state encoding and the default bubble instruction.
package pipe_stage_latch_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // nothing held
        ST_FULL  = 2'd1,   // main register holds the head entry
        ST_SKID  = 2'd2    // main and skid registers both hold entries
    } stage_state_e;

    // Default instruction value shown downstream when no entry is held.
    localparam logic [31:0] NOP_IR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pipe_stage_latch_reg32bit.sv
// reg32bit: 32-bit register with write enable and async active-low reset.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous reset, active low; loads RST_VAL
//   en     - write enable
//   d      - next value
//   q      - registered value
module reg32bit #(
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)  q <= RST_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: two-entry (main + skid) valid/ready pipeline register.
// in_ready depends only on the stored state, so there is no combinational
// path from out_ready back upstream.
// Ports:
//   clock, reset          - rising-edge clock, async active-low reset
//   in_valid/in_ready     - upstream handshake; in_pc/in_ir upstream entry
//   flush                 - discard held entries and the current input
//   out_valid/out_ready   - downstream handshake; out_pc/out_ir head entry
//   stall_cnt             - saturating count of cycles stalled by downstream
module pipe_stage_latch
    import pipe_stage_latch_pkg::*;
#(
    parameter int              PC_W   = 32,
    parameter int              IR_W   = 32,
    parameter logic [IR_W-1:0] NOP_IR = IR_W'(NOP_IR_DEFAULT),
    parameter int              CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [IR_W-1:0]  in_ir,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [IR_W-1:0]  out_ir,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_state_e    state, state_nxt;
    logic            main_en, skid_en;
    logic [PC_W-1:0] main_pc, skid_pc, main_pc_d, skid_pc_d;
    logic [IR_W-1:0] main_ir, skid_ir, main_ir_d, skid_ir_d;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    // Next state and register load controls
    always_comb begin
        state_nxt = state;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_pc_d = in_pc;
        main_ir_d = in_ir;
        skid_pc_d = in_pc;
        skid_ir_d = in_ir;
        if (flush) begin
            // Flush wins: both registers return to the bubble value.
            state_nxt = ST_EMPTY;
            main_en   = 1'b1;
            skid_en   = 1'b1;
            main_pc_d = '0;
            main_ir_d = NOP_IR;
            skid_pc_d = '0;
            skid_ir_d = NOP_IR;
        end else begin
            unique case (state)
                ST_EMPTY: if (in_valid) begin
                    state_nxt = ST_FULL;
                    main_en   = 1'b1;
                end
                ST_FULL: begin
                    if (in_valid && out_ready) begin
                        main_en = 1'b1;
                    end else if (out_ready) begin
                        state_nxt = ST_EMPTY;
                    end else if (in_valid) begin
                        state_nxt = ST_SKID;
                        skid_en   = 1'b1;
                    end
                end
                ST_SKID: if (out_ready) begin
                    // Head leaves; the older waiting entry becomes the head.
                    state_nxt = ST_FULL;
                    main_en   = 1'b1;
                    main_pc_d = skid_pc;
                    main_ir_d = skid_ir;
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Outputs decoded from state only
    always_comb begin
        in_ready  = (state != ST_SKID);
        out_valid = (state != ST_EMPTY);
        out_pc    = out_valid ? main_pc : '0;
        out_ir    = out_valid ? main_ir : NOP_IR;
    end

    // Entry storage
    generate
        if (PC_W == 32 && IR_W == 32) begin : g_r32
            reg32bit #(.RST_VAL(32'h0)) u_main_pc (
                .clock(clock), .reset(reset), .en(main_en), .d(main_pc_d), .q(main_pc));
            reg32bit #(.RST_VAL(NOP_IR)) u_main_ir (
                .clock(clock), .reset(reset), .en(main_en), .d(main_ir_d), .q(main_ir));
            reg32bit #(.RST_VAL(32'h0)) u_skid_pc (
                .clock(clock), .reset(reset), .en(skid_en), .d(skid_pc_d), .q(skid_pc));
            reg32bit #(.RST_VAL(NOP_IR)) u_skid_ir (
                .clock(clock), .reset(reset), .en(skid_en), .d(skid_ir_d), .q(skid_ir));
        end else begin : g_gen
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    main_pc <= '0;
                    main_ir <= NOP_IR;
                    skid_pc <= '0;
                    skid_ir <= NOP_IR;
                end else begin
                    if (main_en) begin
                        main_pc <= main_pc_d;
                        main_ir <= main_ir_d;
                    end
                    if (skid_en) begin
                        skid_pc <= skid_pc_d;
                        skid_ir <= skid_ir_d;
                    end
                end
            end
        end
    endgenerate

    // Downstream stall counter; flush deliberately does not touch it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage_latch.sv
module tb_pipe_stage_latch;

    localparam int          CNT_W = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clock, reset;
    logic             in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]      in_pc, in_ir, out_pc, out_ir;
    logic [CNT_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_latch #(.PC_W(32), .IR_W(32), .NOP_IR(NOP), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ir(in_ir),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir),
        .stall_cnt(stall_cnt));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic             iv;
        logic [31:0]      pc;
        logic [31:0]      ir;
        logic             fl;
        logic             ordy;
        logic             e_ov;
        logic [31:0]      e_pc;
        logic [31:0]      e_ir;
        logic             e_ird;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [31:0] pc, logic [31:0] ir, logic fl,
                                logic ordy, logic e_ov, logic [31:0] e_pc,
                                logic [31:0] e_ir, logic e_ird, logic [CNT_W-1:0] e_cnt);
        vec_t v;
        v.iv = iv; v.pc = pc; v.ir = ir; v.fl = fl; v.ordy = ordy;
        v.e_ov = e_ov; v.e_pc = e_pc; v.e_ir = e_ir; v.e_ird = e_ird; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_all(string tag, logic ov, logic [31:0] pc, logic [31:0] ir,
                             logic ird, logic [CNT_W-1:0] cnt);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        check({tag, ".out_pc"},    64'(out_pc),    64'(pc));
        check({tag, ".out_ir"},    64'(out_ir),    64'(ir));
        check({tag, ".in_ready"},  64'(in_ready),  64'(ird));
        check({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(cnt));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(logic iv, logic [31:0] pc, logic [31:0] ir, logic fl, logic ordy);
        in_valid = iv; in_pc = pc; in_ir = ir; flush = fl; out_ready = ordy;
    endtask

    vec_t vt[18];

    initial begin
        // Each row: inputs applied for one cycle, then outputs expected after the edge.
        vt[0]  = mk(1, 32'h04, 32'h2000_0001, 0, 0,  1, 32'h04, 32'h2000_0001, 1, 0);
        vt[1]  = mk(0, 32'h00, 32'h0,         0, 1,  0, 32'h00, NOP,           1, 0);
        vt[2]  = mk(1, 32'h00, 32'hA0,        0, 1,  1, 32'h00, 32'hA0,        1, 0);
        vt[3]  = mk(1, 32'h04, 32'hA1,        0, 1,  1, 32'h04, 32'hA1,        1, 0);
        vt[4]  = mk(1, 32'h08, 32'hA2,        0, 1,  1, 32'h08, 32'hA2,        1, 0);
        vt[5]  = mk(0, 32'h00, 32'h0,         0, 1,  0, 32'h00, NOP,           1, 0);
        vt[6]  = mk(1, 32'h04, 32'hB1,        0, 0,  1, 32'h04, 32'hB1,        1, 0);
        vt[7]  = mk(1, 32'h08, 32'hB2,        0, 0,  1, 32'h04, 32'hB1,        0, 1);
        vt[8]  = mk(1, 32'h0C, 32'hB3,        0, 0,  1, 32'h04, 32'hB1,        0, 2);
        vt[9]  = mk(0, 32'h00, 32'h0,         0, 1,  1, 32'h08, 32'hB2,        1, 2);
        vt[10] = mk(0, 32'h00, 32'h0,         0, 1,  0, 32'h00, NOP,           1, 2);
        vt[11] = mk(1, 32'h10, 32'hC0,        0, 0,  1, 32'h10, 32'hC0,        1, 2);
        vt[12] = mk(1, 32'h14, 32'hC1,        0, 0,  1, 32'h10, 32'hC0,        0, 3);
        vt[13] = mk(1, 32'h18, 32'hC2,        1, 0,  0, 32'h00, NOP,           1, 4);
        vt[14] = mk(0, 32'h00, 32'h0,         0, 1,  0, 32'h00, NOP,           1, 4);
        vt[15] = mk(1, 32'h20, 32'hD0,        0, 1,  1, 32'h20, 32'hD0,        1, 4);
        vt[16] = mk(1, 32'h24, 32'hD1,        1, 1,  0, 32'h00, NOP,           1, 4);
        vt[17] = mk(1, 32'h28, 32'hD2,        1, 1,  0, 32'h00, NOP,           1, 4);

        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        #12;
        check_all("in_reset", 0, 0, NOP, 1, 0);
        step();
        reset = 1'b1;
        step();
        check_all("post_reset", 0, 0, NOP, 1, 0);

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].iv, vt[i].pc, vt[i].ir, vt[i].fl, vt[i].ordy);
            step();
            check_all($sformatf("vec%0d", i), vt[i].e_ov, vt[i].e_pc, vt[i].e_ir,
                      vt[i].e_ird, vt[i].e_cnt);
        end

        // Saturation: hold one entry with downstream stalled well past wrap point.
        drive(1, 32'h30, 32'hE0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < (1 << CNT_W) + 5; i++) step();
        check_all("saturate", 1, 32'h30, 32'hE0, 1, {CNT_W{1'b1}});

        // Fill the skid, then pull reset low between edges.
        drive(1, 32'h40, 32'hF0, 0, 0);
        step();
        check_all("skid_before_reset", 1, 32'h30, 32'hE0, 0, {CNT_W{1'b1}});
        #2 reset = 1'b0;
        #1;
        check_all("async_reset", 0, 0, NOP, 1, 0);
        drive(0, 0, 0, 0, 1);
        step();
        reset = 1'b1;
        step();
        check_all("after_reset_release", 0, 0, NOP, 1, 0);

        drive(1, 32'h44, 32'h55, 0, 1);
        step();
        check_all("restart", 1, 32'h44, 32'h55, 1, 0);
        drive(0, 0, 0, 0, 1);
        step();
        check_all("restart_drain", 0, 0, NOP, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
